// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared screen geometry, clamp bounds, FSM state codes and clamp helper
package player_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Sprite half-extents around the centre point (left/right, top/bottom).
    localparam int SPR_HX_L = 15;
    localparam int SPR_HX_R = 16;
    localparam int SPR_HY_T = 19;
    localparam int SPR_HY_B = 18;

    // The larger half-extent on each axis bounds the centre so no part of
    // the sprite ever leaves the visible area.
    localparam int X_MIN = SPR_HX_R;
    localparam int X_MAX = SCREEN_W - SPR_HX_R;
    localparam int Y_MIN = SPR_HY_T;
    localparam int Y_MAX = SCREEN_H - SPR_HY_T;

    localparam int RESPAWN_Y    = 461;
    localparam int RESPAWN_STEP = 2;

    // FSM state codes
    localparam logic [1:0] ALIVE   = 2'd0;
    localparam logic [1:0] DEAD    = 2'd1;
    localparam logic [1:0] RESPAWN = 2'd2;

    // Bit positions within the synchronized button bus
    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_FOCUS = 4;

    // Saturate a signed 11-bit candidate coordinate into [lo, hi].
    function automatic logic [9:0] clamp(input logic signed [10:0] v, input int lo, input int hi);
        logic signed [10:0] lo_s;
        logic signed [10:0] hi_s;
        lo_s = 11'(lo);
        hi_s = 11'(hi);
        if (v < lo_s)
            return lo_s[9:0];
        else if (v > hi_s)
            return hi_s[9:0];
        else
            return v[9:0];
    endfunction

endpackage

// File: rtl/player_motion_btn_sync.sv
// rtl/player_motion_btn_sync.sv - parameterized-width 2-flop synchronizer
// Ports: clk, rst (sync active-high), d (async in, W bits), q (synchronized out, W bits)
module btn_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/player_motion.sv
// rtl/player_motion.sv - frame-rate player position controller with hit/dead/respawn/invuln sequence
// Ports: clk, rst (sync active-high), vsync (active-low), btn_up/down/left/right/focus (async),
//        hit (1-cycle pulse); pos_x, pos_y (10-bit centre), visible, invuln (all registered).
// Optional: define PLAYER_FOCUS_EN to enable the btn_focus slow-move step (FOCUS_SPEED).
module player_motion
    import player_pkg::*;
#(
    parameter int SPEED         = 4,
    parameter int FOCUS_SPEED   = 2,
    parameter int START_X       = 320,
    parameter int START_Y       = 400,
    parameter int DEAD_FRAMES   = 60,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_SHIFT   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_focus,
    input  logic       hit,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       visible,
    output logic       invuln
);

    localparam logic [15:0] INV_LOAD  = 16'(INVULN_FRAMES);
    localparam logic [15:0] DEAD_LAST = 16'(DEAD_FRAMES - 1);

`ifdef PLAYER_FOCUS_EN
    localparam int BW = 5;
    logic [BW-1:0] btn_raw;
    assign btn_raw = {btn_focus, btn_right, btn_left, btn_down, btn_up};
`else
    localparam int BW = 4;
    logic [BW-1:0] btn_raw;
    logic          unused_focus;
    assign btn_raw      = {btn_right, btn_left, btn_down, btn_up};
    assign unused_focus = btn_focus;
`endif

    logic [BW-1:0] btn_s;

    btn_sync #(.W(BW)) u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_s)
    );

    logic focus_held;
`ifdef PLAYER_FOCUS_EN
    assign focus_held = btn_s[B_FOCUS];
`else
    assign focus_held = 1'b0;
`endif

    logic signed [10:0] step;
    assign step = focus_held ? 11'(FOCUS_SPEED) : 11'(SPEED);

    logic vsync_q;
    logic tick;
    logic [1:0] state;
    logic hit_pend;
    logic [15:0] frame_cnt;
    logic [15:0] inv_cnt;
    logic [15:0] inv_next;
    logic signed [10:0] dx, dy, nx, ny, ry;

    // Opposing buttons cancel; diagonals take the full step on both axes.
    always_comb begin
        dx = '0;
        dy = '0;
        if (btn_s[B_RIGHT] && !btn_s[B_LEFT])
            dx = step;
        else if (btn_s[B_LEFT] && !btn_s[B_RIGHT])
            dx = -step;
        if (btn_s[B_DOWN] && !btn_s[B_UP])
            dy = step;
        else if (btn_s[B_UP] && !btn_s[B_DOWN])
            dy = -step;
    end

    assign nx       = $signed({1'b0, pos_x}) + dx;
    assign ny       = $signed({1'b0, pos_y}) + dy;
    assign ry       = $signed({1'b0, pos_y}) - 11'(RESPAWN_STEP);
    assign inv_next = inv_cnt - 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q   <= 1'b1;
            tick      <= 1'b0;
            state     <= ALIVE;
            pos_x     <= 10'(START_X);
            pos_y     <= 10'(START_Y);
            visible   <= 1'b1;
            invuln    <= 1'b0;
            hit_pend  <= 1'b0;
            frame_cnt <= '0;
            inv_cnt   <= '0;
        end else begin
            vsync_q <= vsync;
            // Registered falling-edge detect: work happens in the cycle after
            // vsync is first sampled low, so outputs move one clk later.
            tick    <= ~vsync & vsync_q;

            // A hit coinciding with the acting tick lands in hit_pend and
            // is honoured on the following tick.
            if (tick && state == ALIVE && hit_pend)
                hit_pend <= 1'b0;
            else if (hit && state == ALIVE && !invuln)
                hit_pend <= 1'b1;

            if (tick) begin
                case (state)
                    ALIVE: begin
                        if (hit_pend) begin
                            state     <= DEAD;
                            frame_cnt <= '0;
                            visible   <= 1'b0;
                        end else begin
                            pos_x <= clamp(nx, X_MIN, X_MAX);
                            pos_y <= clamp(ny, Y_MIN, Y_MAX);
                            if (inv_cnt != '0) begin
                                inv_cnt <= inv_next;
                                invuln  <= (inv_next != '0);
                                visible <= ~inv_next[BLINK_SHIFT];
                            end
                        end
                    end
                    DEAD: begin
                        if (frame_cnt == DEAD_LAST) begin
                            state     <= RESPAWN;
                            frame_cnt <= '0;
                            pos_x     <= 10'(START_X);
                            pos_y     <= 10'(RESPAWN_Y);
                            visible   <= 1'b1;
                            invuln    <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                    RESPAWN: begin
                        if (ry <= $signed(11'(START_Y))) begin
                            pos_y   <= 10'(START_Y);
                            state   <= ALIVE;
                            inv_cnt <= INV_LOAD;
                            invuln  <= (INV_LOAD != '0);
                            visible <= ~INV_LOAD[BLINK_SHIFT];
                        end else begin
                            pos_y <= clamp(ry, Y_MIN, Y_MAX);
                        end
                    end
                    default: state <= ALIVE;
                endcase
            end
        end
    end

endmodule

// File: doc/player_motion.md
# player_motion

Frame-rate player position controller feeding the VGA compositor's player-position inputs. Synchronizes the direction buttons, updates the player's screen-centre coordinates once per video frame, clamps them to the visible area, and runs the hit → dead → respawn → invulnerable sequence. It also drives a sprite-visible flag, so the compositor can blink or hide the player sprite.

## Interface
Parameters:
- SPEED, 4: pixels moved per frame per axis, normal mode
- FOCUS_SPEED, 2: pixels per frame while focus held (only with PLAYER_FOCUS_EN)
- START_X, 320: spawn/reset X centre
- START_Y, 400: spawn/reset Y centre
- DEAD_FRAMES, 60: frames spent in DEAD
- INVULN_FRAMES, 120: invulnerable frames after respawn
- BLINK_SHIFT, 2: blink period = 2^(BLINK_SHIFT+1) frames

Ports:
- Reset is rst, synchronous, active-high; clock is clk.
- clk  in  1  pixel clock, same domain as the VGA timing generator
- rst  in  1  synchronous active-high reset
- vsync  in  1  active-low vertical sync from the timing generator, synchronous to clk
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous push buttons, active-high
- btn_focus  in  1  slow-mode button; ignored without PLAYER_FOCUS_EN
- hit  in  1  one-cycle collision pulse from game logic
- pos_x  out  10  player centre X (to compositor reimux)
- pos_y  out  10  player centre Y (to compositor reimuy)
- visible  out  1  sprite should be drawn
- invuln  out  1  player currently invulnerable

## Operation
- Buttons pass through 2-flop synchronizers. The synchronized values are sampled only on the frame tick.
- Frame tick: one-cycle pulse in the cycle where vsync = 0 and the previous registered vsync = 1 (falling edge).
- Clamp window matches the sprite extent on a 640×480 screen.
  - X range: [16, 624].
  - Y range: [19, 461].
  - Compute next position in 11-bit signed arithmetic, then saturate to the window. Never wrap.
- Opposing buttons held together (left+right, or up+down) produce zero motion on that axis. Diagonals move the full step on both axes, with no normalization.
- State machine, all transitions on a tick only:
  - ALIVE: apply the button step.
    - A hit pulse sets hit_pend only when invuln = 0. Hits during invuln, DEAD or RESPAWN are dropped.
    - At the tick where hit_pend = 1: go to DEAD, clear hit_pend, frame_cnt = 0, visible = 0. No motion is applied on that tick.
  - DEAD: buttons ignored, position frozen, visible = 0.
    - frame_cnt counts ticks.
    - When frame_cnt reaches DEAD_FRAMES−1: go to RESPAWN and load pos = (START_X, 461).
  - RESPAWN: buttons ignored, visible = 1, invuln = 1.
    - pos_y decreases by 2 per tick.
    - At the tick where the new pos_y ≤ START_Y: set pos_y = START_Y, go to ALIVE, load the invulnerability counter with INVULN_FRAMES.
  - ALIVE with the invulnerability counter nonzero:
    - invuln = 1, and the counter decrements each tick.
    - visible = ~counter[BLINK_SHIFT].
    - Reaching 0 gives invuln = 0 and visible = 1.
- A hit pulse arriving in the same cycle as a tick is captured into hit_pend. It takes effect on the following tick.

## Timing
- All outputs are registered.
- Position/flag updates appear exactly 1 clk after the tick cycle, i.e. 2 clk after the first clk where vsync is sampled 0.
- Button-to-sample latency is 2 clk (synchronizer). A press shorter than 2 clk around the tick may be missed; this is acceptable.
- Reset values: pos_x = START_X, pos_y = START_Y, visible = 1, invuln = 0, state ALIVE, hit_pend = 0, all counters 0, synchronizers 0, registered vsync = 1.
- Reset asserted mid-DEAD or mid-RESPAWN returns to the reset values on the next clk edge, with no residual counters.
- Outputs are stable for a whole frame. The compositor may sample them at any time.

## Configuration
- PLAYER_FOCUS_EN defined: btn_focus is synchronized like the other buttons, and the step becomes FOCUS_SPEED while it is held.
- PLAYER_FOCUS_EN undefined: the focus synchronizer and mux are removed, the btn_focus port remains but is ignored, and the step is always SPEED.

## Structure
- The shared package player_pkg holds:
  - SCREEN_W = 640 and SCREEN_H = 480
  - sprite half-extents (X 15/16, Y 19/18)
  - the clamp bounds X_MIN/X_MAX/Y_MIN/Y_MAX
  - RESPAWN_Y = 461 and RESPAWN_STEP = 2
  - the state enum {ALIVE, DEAD, RESPAWN}
- One sub-module: btn_sync, a parameterized-width 2-flop synchronizer instantiated once for the button bus.

## Test plan
- Reset, hold btn_right for 3 frames → pos_x steps 320, 324, 328, 332, each change 2 clk after the vsync falling edge; pos_y stays 400.
- Hold btn_left + btn_right + btn_up from (320,400) → pos_x stays 320, pos_y decreases by 4 per frame. Continue to the top → pos_y saturates at 19, never wraps.
- Drive pos_x to 622, then btn_right → pos_x = 624 and holds there.
- Single hit pulse while ALIVE and not invuln:
  - next tick → visible = 0, position frozen for 60 frames;
  - then pos = (320,461) and pos_y falls by 2 per frame to 400;
  - then invuln = 1 for 120 frames with visible toggling every 4 frames.
- Hit pulse during invuln and during DEAD → ignored, no extra DEAD period. Assert rst in RESPAWN → next clk gives (320,400), visible = 1, invuln = 0.
- With PLAYER_FOCUS_EN, hold btn_focus + btn_down from (320,400) → pos_y 402, 404; without the macro → 404, 408.
